fifo_gray_ptr: RTL and testbench
================================

// Module: fifo_gray_ptr
// PURPOSE
//  Parametrised pointer engine for one side of a dual-clock FIFO. Holds the local
//  binary and gray pointers (AW+1 bits) and converts the synchronised remote gray pointer
//  to binary with a width-generic loop. Produces registered full/empty, almost flags and
//  occupancy. SIDE selects write-side (full) or read-side (empty) semantics. One instance
//  sits in each clock domain, next to the 2-FF pointer synchroniser.
// PARAMETERS
//  DEPTH      8               FIFO entries; power of 2, >= 4
//  AW         $clog2(DEPTH)   address width; pointers are AW+1 bits
//  SIDE       0               0 = write side (full), 1 = read side (empty)
//  ALMOST_TH  2               almost-full/almost-empty threshold, 1..DEPTH-1
// PORTS
//  clk          in   1     local-domain clock
//  rst          in   1     synchronous, active-high reset
//  inc          in   1     push (SIDE=0) or pop (SIDE=1) request
//  remote_gray  in   AW+1  other side's gray pointer, already synchronised into clk
//  accepted     out  1     inc & ~flag (combinational); pointer advances this cycle
//  addr         out  AW    ptr_bin[AW-1:0], RAM address
//  ptr_bin      out  AW+1  registered local binary pointer
//  ptr_gray     out  AW+1  registered local gray pointer, sent to the synchroniser
//  flag         out  1     registered full (SIDE=0) or empty (SIDE=1)
//  almost_flag  out  1     registered almost-full / almost-empty
//  level        out  AW+1  registered occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge): ptr_bin=0, ptr_gray=0, level=0; SIDE=0: flag=0,
//    almost_flag=0; SIDE=1: flag=1, almost_flag=1. Reset overrides inc.
//  - bin_next = ptr_bin + accepted (mod 2^(AW+1)); gray_next = bin_next ^ (bin_next>>1).
//    ptr_bin and ptr_gray both load their next values at every posedge; they are never
//    mismatched.
//  - remote_bin[AW] = remote_gray[AW]; remote_bin[i] = remote_bin[i+1] ^ remote_gray[i],
//    for i = AW-1 down to 0. This conversion is combinational.
//  - Flags are computed from next-state values and registered (latency 1 after the
//    accepting edge):
//    SIDE=0: full = (gray_next == {~remote_gray[AW:AW-1], remote_gray[AW-2:0]})
//    SIDE=1: empty = (gray_next == remote_gray)
//  - level: SIDE=0: bin_next - remote_bin. SIDE=1: remote_bin - bin_next.
//    Arithmetic is AW+1 bits, modulo, and registered.
//  - almost_flag: SIDE=0: level_next >= DEPTH-ALMOST_TH. SIDE=1: level_next <= ALMOST_TH.
//  - inc while flag=1: ignored, accepted=0, pointers hold. There is no overflow or underflow.
//  - Wrap-around: ptr_bin rolls from 2*DEPTH-1 to 0. The MSB toggles on each address wrap.
//    Consecutive ptr_gray values differ in exactly one bit, including across the wrap.
//  - Simultaneous inc and remote_gray change: both are used in the same next-state
//    calculation. A flag can deassert and the next inc is accepted in the following cycle.
//  - remote_gray is trusted to be gray-coded. No checks are made on it.
// TESTING
//  T1 SIDE=0, DEPTH=8, remote_gray=0: hold rst 2 cycles, then release ->
//     ptr_bin=0, ptr_gray=0, flag=0, level=0.
//  T2 SIDE=0: 8 accepted incs with remote_gray=0 -> after the 8th edge, ptr_bin=8,
//     ptr_gray=4'b1100, flag=1, level=8, almost_flag=1 from level 6. A 9th inc gives
//     accepted=0 and the pointer holds.
//  T3 From T2, set remote_gray=4'b0001 (bin 1) -> next edge: flag=0, level=7.
//     An inc on that cycle is accepted: ptr_bin=9, flag=1.
//  T4 SIDE=1, DEPTH=8: after reset, flag=1. Set remote_gray=4'b0010 (bin 3) ->
//     next edge: flag=0, level=3. Three incs -> ptr_bin=3, flag=1, level=0.
//  T5 Wrap: 20 incs with remote tracking to keep non-full/non-empty -> ptr_bin goes
//     15 to 0. Check ptr_gray Hamming distance is 1 on every step, and
//     ptr_gray == ptr_bin ^ (ptr_bin>>1) every cycle.
//  T6 Assert rst mid-burst with inc=1 -> next edge: all outputs at reset values;
//     inc on that edge has no effect. Repeat T2 with DEPTH=16 and ALMOST_TH=4.

Source files
------------

// File: rtl/fifo_gray_ptr.sv
// Pointer engine for one side of a dual-clock FIFO: local binary/gray pointers,
// remote gray-to-binary conversion, registered full/empty, almost flag and occupancy.
module fifo_gray_ptr #(
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter int SIDE      = 0,
  parameter int ALMOST_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [AW:0]   remote_gray,
  output logic          accepted,
  output logic [AW-1:0] addr,
  output logic [AW:0]   ptr_bin,
  output logic [AW:0]   ptr_gray,
  output logic          flag,
  output logic          almost_flag,
  output logic [AW:0]   level
);

  localparam logic        RST_FLAG   = (SIDE != 0);
  localparam logic [AW:0] ALMOST_LVL = (SIDE == 0) ? (AW+1)'(DEPTH - ALMOST_TH)
                                                   : (AW+1)'(ALMOST_TH);

  logic [AW:0] bin_q, bin_d;
  logic [AW:0] gray_q, gray_d;
  logic [AW:0] level_q, level_d;
  logic        flag_q, flag_d;
  logic        almost_q, almost_d;
  logic [AW:0] remote_bin;

  assign accepted = inc & ~flag_q;
  assign bin_d    = bin_q + {{AW{1'b0}}, accepted};
  assign gray_d   = bin_d ^ (bin_d >> 1);

  // Each binary bit is the XOR of all gray bits at and above it.
  always_comb begin
    remote_bin     = '0;
    remote_bin[AW] = remote_gray[AW];
    for (int unsigned k = 1; k <= AW; k++) begin
      remote_bin[AW-k] = remote_bin[AW-k+1] ^ remote_gray[AW-k];
    end
  end

  always_comb begin
    flag_d   = RST_FLAG;
    level_d  = '0;
    almost_d = RST_FLAG;
    if (SIDE == 0) begin
      flag_d   = (gray_d == {~remote_gray[AW:AW-1], remote_gray[AW-2:0]});
      level_d  = bin_d - remote_bin;
      almost_d = (level_d >= ALMOST_LVL);
    end else begin
      flag_d   = (gray_d == remote_gray);
      level_d  = remote_bin - bin_d;
      almost_d = (level_d <= ALMOST_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= RST_FLAG;
      almost_q <= RST_FLAG;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
    end
  end

  assign addr        = bin_q[AW-1:0];
  assign ptr_bin     = bin_q;
  assign ptr_gray    = gray_q;
  assign flag        = flag_q;
  assign almost_flag = almost_q;
  assign level       = level_q;

endmodule

// File: tb/tb_fifo_gray_ptr.sv
// Scoreboard bench: three configurations (write D8, read D8, write D16/TH4) driven
// against an occupancy-count reference model; a monitor per instance checks outputs.
module tb_fifo_gray_ptr;

  typedef struct {
    bit         rst_item;
    bit         acc;
    logic [4:0] bin;
    logic [4:0] gray;
    logic [4:0] lvl;
    bit         fl;
    bit         al;
  } exp_t;

  logic clk = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] to_gray(input int unsigned b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  for (genvar c = 0; c < 3; c++) begin : g
    localparam int DEP  = (c == 2) ? 16 : 8;
    localparam int SD   = (c == 1) ? 1 : 0;
    localparam int TH   = (c == 2) ? 4 : 2;
    localparam int AWC  = $clog2(DEP);
    localparam int W    = AWC + 1;
    localparam int M    = 2 * DEP;

    logic           rst_s, inc_s;
    logic [W-1:0]   rg_s;
    logic           acc_o, fl_o, al_o;
    logic [AWC-1:0] addr_o;
    logic [W-1:0]   bin_o, gray_o, lvl_o;

    int unsigned loc, rem;
    bit          fl;
    bit          done = 1'b0;
    exp_t        q[$];

    fifo_gray_ptr #(.DEPTH(DEP), .SIDE(SD), .ALMOST_TH(TH)) u_dut (
      .clk(clk), .rst(rst_s), .inc(inc_s), .remote_gray(rg_s),
      .accepted(acc_o), .addr(addr_o), .ptr_bin(bin_o), .ptr_gray(gray_o),
      .flag(fl_o), .almost_flag(al_o), .level(lvl_o)
    );

    task automatic do_reset(input bit i);
      exp_t e;
      @(negedge clk);
      rst_s = 1'b1;
      inc_s = i;
      rg_s  = '0;
      loc   = 0;
      rem   = 0;
      fl    = (SD != 0);
      e = '{rst_item: 1'b1, acc: 1'b0, bin: '0, gray: '0, lvl: '0, fl: fl, al: fl};
      q.push_back(e);
    endtask

    // Occupancy model: local/remote transfer counts; level is their difference.
    task automatic step(input bit i, input int unsigned radv);
      exp_t        e;
      bit          a;
      int unsigned lim, lv;
      @(negedge clk);
      rst_s = 1'b0;
      inc_s = i;
      a   = i && !fl;
      lim = (SD == 0) ? loc : loc + DEP;
      rem = (rem + radv > lim) ? lim : rem + radv;
      loc = loc + a;
      rg_s = W'(to_gray(rem % M));
      lv = (SD == 0) ? loc - rem : rem - loc;
      fl = (SD == 0) ? (lv == DEP) : (lv == 0);
      e.rst_item = 1'b0;
      e.acc  = a;
      e.bin  = 5'(loc % M);
      e.gray = to_gray(loc % M);
      e.lvl  = 5'(lv);
      e.fl   = fl;
      e.al   = (SD == 0) ? (lv >= DEP - TH) : (lv <= TH);
      q.push_back(e);
    endtask

    task automatic directed();
      if (SD == 0) begin
        for (int i = 0; i < DEP + 1; i++) step(1'b1, 0);
        step(1'b1, 1);
        step(1'b1, 0);
      end else begin
        step(1'b1, 0);
        step(1'b0, 3);
        for (int i = 0; i < 4; i++) step(1'b1, 0);
      end
    endtask

    initial begin
      int unsigned p;
      rst_s = 1'b1;
      inc_s = 1'b0;
      rg_s  = '0;
      loc   = 0;
      rem   = 0;
      fl    = (SD != 0);
      p     = 50;
      do_reset(1'b0);
      do_reset(1'b0);
      directed();
      for (int n = 0; n < 400; n++) begin
        if (n % 50 == 0) p = $urandom_range(20, 80);
        if (n == 200) begin
          do_reset(1'b1);
          directed();
        end else begin
          step($urandom_range(0, 99) < p,
               ($urandom_range(0, 99) < 100 - p) ? $urandom_range(1, 2) : 0);
        end
      end
      @(negedge clk);
      inc_s = 1'b0;
      done  = 1'b1;
    end

    initial begin
      exp_t       e;
      logic [4:0] prev_gray, prev_bin;
      prev_gray = '0;
      prev_bin  = '0;
      forever begin
        @(negedge clk);
        #2;
        if (q.size() != 0) begin
          e = q.pop_front();
          if (!e.rst_item) chk($sformatf("c%0d accepted", c), 32'(acc_o), 32'(e.acc));
          @(posedge clk);
          #1;
          chk($sformatf("c%0d ptr_bin", c),  32'(bin_o),  32'(e.bin));
          chk($sformatf("c%0d addr", c),     32'(addr_o), 32'(e.bin[AWC-1:0]));
          chk($sformatf("c%0d ptr_gray", c), 32'(gray_o), 32'(e.gray));
          chk($sformatf("c%0d level", c),    32'(lvl_o),  32'(e.lvl));
          chk($sformatf("c%0d flag", c),     32'(fl_o),   32'(e.fl));
          chk($sformatf("c%0d almost", c),   32'(al_o),   32'(e.al));
          if (!e.rst_item)
            chk($sformatf("c%0d gray_step", c), 32'($countones(5'(gray_o) ^ prev_gray)),
                (e.bin != prev_bin) ? 32'd1 : 32'd0);
          prev_gray = 5'(gray_o);
          prev_bin  = e.bin;
        end
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int k = 0; k < 20000 && !all_done; k++) begin
      @(posedge clk);
      all_done = g[0].done && g[1].done && g[2].done;
    end
    chk("completion", 32'(all_done), 32'd1);
    repeat (3) @(posedge clk);
    chk("c0 queue_drained", 32'(g[0].q.size()), 32'd0);
    chk("c1 queue_drained", 32'(g[1].q.size()), 32'd0);
    chk("c2 queue_drained", 32'(g[2].q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
